gpio_ext: RTL and testbench
===========================

# gpio_ext

Parametrised next-generation GPIO controller for the CPLD CSR bus: up to 8 pins with output enable, per-pin rising/falling/both-edge interrupt selection, write-one-to-clear pending bits, a level-sensitive interrupt output and an optional per-pin input debounce filter. It sits on the same 5-bit CSR bus as the other CPLD peripherals. Its `irq` feeds the interrupt aggregator.

## Interface
Parameters:
- `BASE_ADDR`, 5'h0: CSR base address; the block decodes `BASE_ADDR+0` to `BASE_ADDR+7`.
- `NUM_GPIOS`, 8: number of pins, 1..8; unused CSR data bits read 0 and are ignored on write.
- `DFL_STATE`, all 0: reset value of `out`.
- `DFL_OE`, all 0: reset value of `oe`.
- `DEBOUNCE_CYCLES`, 16: filter length in clocks, 1..255. Used only with `GPIO_DEBOUNCE_EN`.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `csr_a` input 5: CSR address.
- `csr_di` input 8: CSR write data.
- `csr_we` input 1: CSR write strobe, one cycle per write.
- `csr_do` output 8: CSR read data, combinational from `csr_a`; 0 when the address is outside the block.
- `in` input NUM_GPIOS: asynchronous pin inputs.
- `out` output NUM_GPIOS: registered pin output values.
- `oe` output NUM_GPIOS: registered output enables.
- `irq` output 1: registered, level-high interrupt.

## Operation
- Input path per pin: `in` → 2-flop synchronizer (`s`) → filter (`f`) → previous-value flop (`f_d`).
  - `rise = f & ~f_d`.
  - `fall = ~f & f_d`.
- Registers at offsets from `BASE_ADDR`:
  - 0 OE: R/W.
  - 1 OUT: R/W.
  - 2 IN: RO, returns `f`.
  - 3 IE: R/W, interrupt enable.
  - 4 IP: read pending; write-1-to-clear.
  - 5 POS: R/W, rising-edge select.
  - 6 NEG: R/W, falling-edge select.
  - 7 DBE: R/W, debounce enable.
- Edge event per pin: `ev = (rise & POS) | (fall & NEG)`.
  - Setting both POS and NEG selects both edges.
  - Clearing both disables event capture; IP is then not set for that pin.
- IP update each cycle: `ip <= (ip & ~clr) | ev`. `clr` is `csr_di` when writing offset 4, else 0. An event in the same cycle as its clear wins: the bit stays 1.
- IP bits set regardless of IE, so software can poll.
- `irq <= |(ip_next & ie_next)`, using the post-update values.
  - Enabling IE on an already-pending bit raises `irq` on the next cycle.
  - Clearing the last enabled pending bit, or its IE, drops `irq` on the next cycle.
- `out` and `oe` change only on CSR writes and reset. No read side effects anywhere.
- Reset values:
  - `oe` = DFL_OE; `out` = DFL_STATE.
  - IE, IP, POS, NEG, DBE = 0.
  - `irq` = 0.
  - Synchronizer, filter and `f_d` flops = 0. Counters = 0.
  - Reset mid-debounce abandons the count. A pin held high through reset produces one rising event after reset, which is ignored unless POS is set.

## Timing
- CSR write takes effect at the clock edge where `csr_we`=1. Read data is valid in the same cycle as `csr_a`.
- Filter bypassed (DBE bit 0, or macro off): `f = s`.
  - A pin change stable before edge 0 is in `s` after edge 1.
  - `ev` is high in the cycle after edge 1, so IP and `irq` are set at edge 2.
  - Input-to-`irq` latency is 2 clocks after the first sampling edge.
- Filter active: per-pin counter, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s == f`, the counter resets to 0.
  - Else, if the count equals `DEBOUNCE_CYCLES-1`: `f <= s` and the counter goes to 0.
  - Else the counter increments.
  - So `f` follows `s` only after DEBOUNCE_CYCLES consecutive mismatching cycles. Any shorter glitch is discarded and the counter restarts.
- Toggling DBE for a pin resets its counter. `f` keeps its value; it is never forced.

## Configuration
- `GPIO_DEBOUNCE_EN` defined:
  - Counters, the filter and the DBE register are built.
  - DBE bit 1 filters that pin.
- `GPIO_DEBOUNCE_EN` undefined:
  - No counters are built and `f = s` for all pins.
  - DBE reads 0 and writes are ignored.
  - `DEBOUNCE_CYCLES` is unused.

## Test plan
- Reset with DFL_OE=8'h0F, DFL_STATE=8'hA5 → reads at offsets 0/1/3/4/5/6/7 return 0F/A5/00/00/00/00/00; `irq`=0.
- POS=8'h01, IE=8'h01, pin0 0→1 → IP=8'h01 and `irq`=1 two clocks after the first sampling edge. Pin0 1→0 → no new event. Write 8'h01 to offset 4 → IP=0 and `irq`=0 the next cycle.
- POS=NEG=8'h04, IE=0, pin2 pulses high for 5 clocks → IP=8'h04 after the rise, `irq` stays 0. Then write IE=8'h04 → `irq`=1 on the next cycle.
- Rising event on pin3 in the exact cycle of a W1C write of 8'h08 → IP bit3 reads 1 afterwards.
- With macro, DEBOUNCE_CYCLES=16, DBE=8'h01, POS=8'h01:
  - 15-cycle high glitch on pin0 → IN bit0 stays 0 and IP stays 0.
  - 16-cycle high pulse → IN bit0=1 and IP=8'h01.
- NUM_GPIOS=4, write 8'hFF to OUT → OUT reads 8'h0F and `out`=4'hF. Read of BASE_ADDR+8 returns 0.

Source files
------------

// File: rtl/gpio_ext_if.sv
// CSR bus shared by the CPLD peripherals: 5-bit address, 8-bit data, single-cycle write strobe.
// Read data is combinational from the address.
interface gpio_ext_if;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;

    modport master (output csr_a, output csr_di, output csr_we, input csr_do);
    modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);
endinterface

// File: rtl/gpio_ext.sv
// GPIO controller with per-pin edge interrupts, W1C pending bits and a level irq.
// Define GPIO_DEBOUNCE_EN to build the per-pin debounce filter and the DBE register.
module gpio_ext #(
    parameter logic [4:0] BASE_ADDR       = 5'h0,
    parameter int         NUM_GPIOS       = 8,
    parameter logic [7:0] DFL_STATE       = 8'h00,
    parameter logic [7:0] DFL_OE          = 8'h00,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_ext_if.slave            csr,
    input  logic [NUM_GPIOS-1:0] in,
    output logic [NUM_GPIOS-1:0] out,
    output logic [NUM_GPIOS-1:0] oe,
    output logic                 irq
);
    localparam int N = NUM_GPIOS;

    if (NUM_GPIOS < 1 || NUM_GPIOS > 8 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
        $error("gpio_ext: NUM_GPIOS must be 1..8 and DEBOUNCE_CYCLES 1..255");
    end

    logic [4:0]   off;
    logic         hit;
    logic         wr;
    logic [N-1:0] wdata;

    assign off   = csr.csr_a - BASE_ADDR;
    assign hit   = (off[4:3] == 2'b00);
    assign wr    = csr.csr_we & hit;
    assign wdata = csr.csr_di[N-1:0];

    logic [N-1:0] ie, ip, pos, neg;
    logic [N-1:0] sync1, s, f, f_d;
    logic [N-1:0] dbe_rd;
    logic [N-1:0] ev, clr, ip_next, ie_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= in;
            s     <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  dbe, dbe_next, filt;
    logic [CW-1:0] cnt [N];

    assign dbe_next = (wr && off[2:0] == 3'd7) ? wdata : dbe;
    assign dbe_rd   = dbe;
    assign f        = (dbe & filt) | (~dbe & s);

    // While bypassed, filt shadows s so enabling the filter starts from the pin's current level.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbe  <= '0;
            filt <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            dbe <= dbe_next;
            for (int i = 0; i < N; i++) begin
                if (dbe_next[i] != dbe[i]) begin
                    cnt[i] <= '0;
                end else if (!dbe[i]) begin
                    filt[i] <= s[i];
                    cnt[i]  <= '0;
                end else if (s[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= s[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign dbe_rd = '0;
    assign f      = s;
`endif

    assign ev      = (f & ~f_d & pos) | (~f & f_d & neg);
    assign clr     = (wr && off[2:0] == 3'd4) ? wdata : '0;
    assign ip_next = (ip & ~clr) | ev;
    assign ie_next = (wr && off[2:0] == 3'd3) ? wdata : ie;

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= DFL_STATE[N-1:0];
            oe  <= DFL_OE[N-1:0];
            ie  <= '0;
            ip  <= '0;
            pos <= '0;
            neg <= '0;
            f_d <= '0;
            irq <= 1'b0;
        end else begin
            if (wr && off[2:0] == 3'd0) oe  <= wdata;
            if (wr && off[2:0] == 3'd1) out <= wdata;
            if (wr && off[2:0] == 3'd5) pos <= wdata;
            if (wr && off[2:0] == 3'd6) neg <= wdata;
            f_d <= f;
            ie  <= ie_next;
            ip  <= ip_next;
            irq <= |(ip_next & ie_next);
        end
    end

    logic [N-1:0] rd;

    always_comb begin
        rd = '0;
        case (off[2:0])
            3'd0:    rd = oe;
            3'd1:    rd = out;
            3'd2:    rd = f;
            3'd3:    rd = ie;
            3'd4:    rd = ip;
            3'd5:    rd = pos;
            3'd6:    rd = neg;
            default: rd = dbe_rd;
        endcase
    end

    assign csr.csr_do = hit ? 8'(rd) : 8'h00;
endmodule

// File: tb/tb_gpio_ext.sv
// Directed bench for gpio_ext: an 8-pin instance with non-zero defaults and a 4-pin instance at 0x10.
module tb_gpio_ext;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst;
    logic [7:0] pins;
    logic [7:0] out0, oe0;
    logic       irq0;
    logic [3:0] pins1, out1, oe1;
    logic       irq1;
    logic [7:0] rdv;

    int vectors = 0;
    int miscompares = 0;

    gpio_ext_if bus0 ();
    gpio_ext_if bus1 ();

    gpio_ext #(
        .BASE_ADDR(5'h00), .NUM_GPIOS(8), .DFL_STATE(8'hA5), .DFL_OE(8'h0F), .DEBOUNCE_CYCLES(16)
    ) u0 (
        .clk(clk), .rst(rst), .csr(bus0.slave), .in(pins), .out(out0), .oe(oe0), .irq(irq0)
    );

    gpio_ext #(
        .BASE_ADDR(5'h10), .NUM_GPIOS(4), .DFL_STATE(8'h00), .DFL_OE(8'h00), .DEBOUNCE_CYCLES(16)
    ) u1 (
        .clk(clk), .rst(rst), .csr(bus1.slave), .in(pins1), .out(out1), .oe(oe1), .irq(irq1)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic [4:0] a, input logic [7:0] d);
        bus0.csr_a  = a;
        bus0.csr_di = d;
        bus0.csr_we = 1'b1;
        tick();
        bus0.csr_we = 1'b0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [7:0] d);
        bus1.csr_a  = a;
        bus1.csr_di = d;
        bus1.csr_we = 1'b1;
        tick();
        bus1.csr_we = 1'b0;
    endtask

    task automatic rd0(input string tag, input logic [4:0] a, input logic [7:0] exp);
        bus0.csr_a = a;
        #1;
        rdv = bus0.csr_do;
        check(tag, rdv, exp);
    endtask

    task automatic rd1(input string tag, input logic [4:0] a, input logic [7:0] exp);
        bus1.csr_a = a;
        #1;
        rdv = bus1.csr_do;
        check(tag, rdv, exp);
    endtask

    initial begin
        rst = 1'b1;
        pins = 8'h00;
        pins1 = 4'h0;
        bus0.csr_a = 5'h0; bus0.csr_di = 8'h00; bus0.csr_we = 1'b0;
        bus1.csr_a = 5'h0; bus1.csr_di = 8'h00; bus1.csr_we = 1'b0;
        tick(3);
        rst = 1'b0;

        // reset state
        rd0("rst_oe", 5'd0, 8'h0F);
        rd0("rst_out", 5'd1, 8'hA5);
        rd0("rst_in", 5'd2, 8'h00);
        rd0("rst_ie", 5'd3, 8'h00);
        rd0("rst_ip", 5'd4, 8'h00);
        rd0("rst_pos", 5'd5, 8'h00);
        rd0("rst_neg", 5'd6, 8'h00);
        rd0("rst_dbe", 5'd7, 8'h00);
        check("rst_irq", {7'd0, irq0}, 8'h00);
        check("rst_out_pin", out0, 8'hA5);
        check("rst_oe_pin", oe0, 8'h0F);
        tick();

        // rising edge on pin0 with IE: irq two clocks after first sampling edge
        wr0(5'd5, 8'h01);
        wr0(5'd3, 8'h01);
        pins[0] = 1'b1;
        tick(2);
        check("rise_irq_early", {7'd0, irq0}, 8'h00);
        tick();
        check("rise_irq", {7'd0, irq0}, 8'h01);
        rd0("rise_ip", 5'd4, 8'h01);
        pins[0] = 1'b0;
        tick(5);
        rd0("fall_no_event_ip", 5'd4, 8'h01);
        wr0(5'd4, 8'h01);
        rd0("w1c_ip", 5'd4, 8'h00);
        check("w1c_irq", {7'd0, irq0}, 8'h00);

        // both-edge select, IE off, then enable IE on pending bit
        wr0(5'd3, 8'h00);
        wr0(5'd5, 8'h04);
        wr0(5'd6, 8'h04);
        pins[2] = 1'b1;
        tick(3);
        rd0("both_rise_ip", 5'd4, 8'h04);
        tick(2);
        pins[2] = 1'b0;
        tick(5);
        rd0("both_ip", 5'd4, 8'h04);
        check("both_irq_off", {7'd0, irq0}, 8'h00);
        wr0(5'd3, 8'h04);
        check("ie_enable_irq", {7'd0, irq0}, 8'h01);
        wr0(5'd3, 8'h00);
        check("ie_disable_irq", {7'd0, irq0}, 8'h00);
        wr0(5'd4, 8'h04);
        rd0("clr_pin2_ip", 5'd4, 8'h00);

        // event in the same cycle as its clear wins
        wr0(5'd5, 8'h08);
        wr0(5'd6, 8'h00);
        pins[3] = 1'b1;
        tick(2);
        wr0(5'd4, 8'h08);
        rd0("ev_beats_clr", 5'd4, 8'h08);
        wr0(5'd4, 8'h08);
        rd0("clr_after_ev", 5'd4, 8'h00);

        // no edge selected: no capture; IN readback
        wr0(5'd5, 8'h00);
        pins[1] = 1'b1;
        tick(4);
        rd0("in_read", 5'd2, 8'h0A);
        pins[1] = 1'b0;
        tick(4);
        rd0("no_sel_ip", 5'd4, 8'h00);
        pins = 8'h00;
        tick(4);

        // outputs change only on writes
        wr0(5'd1, 8'h5A);
        check("out_pin", out0, 8'h5A);
        rd0("out_rd", 5'd1, 8'h5A);
        wr0(5'd0, 8'hF0);
        check("oe_pin", oe0, 8'hF0);
        rd0("out_of_range", 5'd8, 8'h00);

`ifdef GPIO_DEBOUNCE_EN
        wr0(5'd7, 8'h01);
        rd0("dbe_rd", 5'd7, 8'h01);
        wr0(5'd5, 8'h01);
        pins[0] = 1'b1;
        tick(15);
        pins[0] = 1'b0;
        tick(20);
        rd0("glitch15_in", 5'd2, 8'h00);
        rd0("glitch15_ip", 5'd4, 8'h00);
        pins[0] = 1'b1;
        tick(16);
        pins[0] = 1'b0;
        tick(4);
        rd0("pulse16_in", 5'd2, 8'h01);
        rd0("pulse16_ip", 5'd4, 8'h01);
        tick(25);
        rd0("pulse16_in_low", 5'd2, 8'h00);
`else
        wr0(5'd7, 8'hFF);
        rd0("dbe_absent", 5'd7, 8'h00);
`endif

        // narrow instance
        rd1("n4_rst_oe", 5'h10, 8'h00);
        wr1(5'h11, 8'hFF);
        rd1("n4_out_rd", 5'h11, 8'h0F);
        check("n4_out_pin", {4'h0, out1}, 8'h0F);
        rd1("n4_base_plus8", 5'h18, 8'h00);
        rd1("n4_below_base", 5'h08, 8'h00);
        check("n4_irq", {7'd0, irq1}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
